// File: rtl/host_direct_responder.sv
// host_direct_responder: responder for HostDirect commands.
// Each accepted command becomes one single-beat, line-contained access on the
// 512-bit host AXI master port: a write for NIC-to-host, a read for host-to-NIC.
// The command's cmd_id comes back with the response, plus read data for reads.
//
// Build option: define PSPIN_HOSTDIRECT_READ_EN to enable host-to-NIC reads.
// When it is not defined, no AR traffic is ever issued. A legal read command
// is then answered with err=1 and data=0.

package pspin_cfg_pkg;

  localparam int unsigned HOST_AXI_AW = 64;
  localparam int unsigned HOST_AXI_DW = 512;
  localparam int unsigned HOST_AXI_IW = 8;
  localparam int unsigned HOST_AXI_UW = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [HOST_AXI_IW-1:0]   id;
    logic [HOST_AXI_AW-1:0]   addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [5:0]               atop;
    logic [HOST_AXI_UW-1:0]   user;
  } host_aw_chan_t;

  typedef struct packed {
    logic [HOST_AXI_DW-1:0]   data;
    logic [HOST_AXI_DW/8-1:0] strb;
    logic                     last;
    logic [HOST_AXI_UW-1:0]   user;
  } host_w_chan_t;

  typedef struct packed {
    logic [HOST_AXI_IW-1:0]   id;
    logic [1:0]               resp;
    logic [HOST_AXI_UW-1:0]   user;
  } host_b_chan_t;

  typedef struct packed {
    logic [HOST_AXI_IW-1:0]   id;
    logic [HOST_AXI_AW-1:0]   addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [HOST_AXI_UW-1:0]   user;
  } host_ar_chan_t;

  typedef struct packed {
    logic [HOST_AXI_IW-1:0]   id;
    logic [HOST_AXI_DW-1:0]   data;
    logic [1:0]               resp;
    logic                     last;
    logic [HOST_AXI_UW-1:0]   user;
  } host_r_chan_t;

  typedef struct packed {
    host_aw_chan_t aw;
    logic          aw_valid;
    host_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    host_ar_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } host_req_t;

  typedef struct packed {
    logic          aw_ready;
    logic          ar_ready;
    logic          w_ready;
    logic          b_valid;
    host_b_chan_t  b;
    logic          r_valid;
    host_r_chan_t  r;
  } host_resp_t;

  typedef logic [15:0] pspin_cmd_id_t;

  typedef struct packed {
    logic                   nic_to_host;
    logic [HOST_AXI_AW-1:0] host_addr;
    logic [HOST_AXI_DW-1:0] imm_data;
    logic [31:0]            imm_data_size;
  } pspin_host_direct_cmd_t;

  typedef struct packed {
    pspin_host_direct_cmd_t host_direct_cmd;
  } pspin_cmd_descr_t;

  typedef struct packed {
    pspin_cmd_id_t    cmd_id;
    logic             generate_event;
    logic             intf_id;
    logic [1:0]       cmd_type;
    pspin_cmd_descr_t descr;
  } pspin_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t          cmd_id;
    logic [HOST_AXI_DW-1:0] imm_data;
  } pspin_cmd_resp_t;

endpackage

module host_direct_responder #(
  parameter int unsigned AXI_ID = 0,
  parameter type host_req_t  = pspin_cfg_pkg::host_req_t,
  parameter type host_resp_t = pspin_cfg_pkg::host_resp_t,
  parameter type cmd_t       = pspin_cfg_pkg::pspin_cmd_t,
  parameter type cmd_resp_t  = pspin_cfg_pkg::pspin_cmd_resp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  cmd_t       cmd_i,
  output host_req_t  host_req_o,
  input  host_resp_t host_resp_i,
  output logic       cmd_resp_valid_o,
  input  logic       cmd_resp_ready_i,
  output cmd_resp_t  cmd_resp_o,
  output logic       cmd_resp_err_o
);

  import pspin_cfg_pkg::*;

  localparam logic [HOST_AXI_IW-1:0] AXI_ID_W = AXI_ID[HOST_AXI_IW-1:0];

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_REQ = 3'd1;
  localparam logic [2:0] S_WR_B   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd5;
`ifdef PSPIN_HOSTDIRECT_READ_EN
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_R   = 3'd4;
`endif

  logic [2:0]             state_q;
  pspin_cmd_id_t          cmd_id_q;
  logic [63:6]            line_q;      // line address; the offset lives in off_q
  logic [511:0]           data_q;
  logic [5:0]             off_q;
  logic [6:0]             n_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic [511:0]           resp_data_q;
  logic                   resp_err_q;

  // Decoded view of the incoming command.
  logic [5:0]             off_in;
  logic [31:0]            size_in;
  logic [6:0]             end_in;
  logic                   illegal_in;

  // Derived per-access values.
  logic [64:0]            mask_wide;
  logic [63:0]            byte_mask;
  logic [63:0]            wstrb;
  logic [511:0]           wdata;

  logic                   aw_hs;
  logic                   w_hs;
  logic                   aw_ok;
  logic                   w_ok;

  // Legality check of the offered command.
  // NOTE: always_comb assigns every output before any condition so no latch is inferred.
  always_comb begin
    off_in     = cmd_i.descr.host_direct_cmd.host_addr[5:0];
    size_in    = cmd_i.descr.host_direct_cmd.imm_data_size;
    // The sum is 7 bits wide so that 63 + 64 cannot wrap. A larger size is
    // already illegal on its own.
    end_in     = {1'b0, off_in} + size_in[6:0];
    illegal_in = (size_in == 32'd0) || (size_in > 32'd64) || (end_in > 7'd64);
  end

  // Byte lanes covered by the access, and the data placed on them.
  always_comb begin
    mask_wide = (65'd1 << n_q) - 65'd1;
    byte_mask = mask_wide[63:0];
    wstrb     = byte_mask << off_q;
    wdata     = data_q << {off_q, 3'b000};
  end

  assign aw_hs = host_req_o.aw_valid && host_resp_i.aw_ready;
  assign w_hs  = host_req_o.w_valid  && host_resp_i.w_ready;
  assign aw_ok = aw_done_q || aw_hs;
  assign w_ok  = w_done_q  || w_hs;

`ifdef PSPIN_HOSTDIRECT_READ_EN
  logic [511:0] rd_data;
  logic         ar_hs;
  logic         r_hs;

  // Align returned read data to byte 0 and clear bytes beyond the request.
  always_comb begin
    rd_data = host_resp_i.r.data >> {off_q, 3'b000};
    for (int i = 0; i < 64; i++) begin
      if (!byte_mask[i]) rd_data[8*i +: 8] = 8'h00;
    end
  end

  assign ar_hs = host_req_o.ar_valid && host_resp_i.ar_ready;
  assign r_hs  = host_req_o.r_ready  && host_resp_i.r_valid;
`endif

  // Drive the AXI master request from the current state.
  always_comb begin
    host_req_o           = '0;
    host_req_o.aw.id     = AXI_ID_W;
    host_req_o.aw.addr   = {line_q, 6'b000000};
    host_req_o.aw.size   = 3'd6;
    host_req_o.aw.burst  = AXI_BURST_INCR;
    host_req_o.w.data    = wdata;
    host_req_o.w.strb    = wstrb;
    host_req_o.w.last    = 1'b1;
    host_req_o.ar.id     = AXI_ID_W;
    host_req_o.ar.addr   = {line_q, 6'b000000};
    host_req_o.ar.size   = 3'd6;
    host_req_o.ar.burst  = AXI_BURST_INCR;
    host_req_o.aw_valid  = (state_q == S_WR_REQ) && !aw_done_q;
    host_req_o.w_valid   = (state_q == S_WR_REQ) && !w_done_q;
    host_req_o.b_ready   = (state_q == S_WR_B);
`ifdef PSPIN_HOSTDIRECT_READ_EN
    host_req_o.ar_valid  = (state_q == S_RD_REQ);
    host_req_o.r_ready   = (state_q == S_RD_R);
`endif
  end

  // Command and response handshake outputs.
  always_comb begin
    cmd_resp_o          = '0;
    cmd_resp_o.cmd_id   = cmd_id_q;
    cmd_resp_o.imm_data = resp_data_q;
  end

  assign cmd_ready_o      = (state_q == S_IDLE);
  assign cmd_resp_valid_o = (state_q == S_RESP);
  assign cmd_resp_err_o   = resp_err_q;

  // Command FSM: latch the command, run the AXI access, then hold the response.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cmd_id_q    <= '0;
      line_q      <= '0;
      data_q      <= '0;
      off_q       <= '0;
      n_q         <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_id_q  <= cmd_i.cmd_id;
            line_q    <= cmd_i.descr.host_direct_cmd.host_addr[63:6];
            data_q    <= cmd_i.descr.host_direct_cmd.imm_data;
            off_q     <= off_in;
            n_q       <= size_in[6:0];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (illegal_in) begin
              resp_data_q <= '0;
              resp_err_q  <= 1'b1;
              state_q     <= S_RESP;
            end else if (cmd_i.descr.host_direct_cmd.nic_to_host) begin
              state_q <= S_WR_REQ;
            end else begin
`ifdef PSPIN_HOSTDIRECT_READ_EN
              state_q <= S_RD_REQ;
`else
              resp_data_q <= '0;
              resp_err_q  <= 1'b1;
              state_q     <= S_RESP;
`endif
            end
          end
        end
        S_WR_REQ: begin
          // AW and W complete independently; move on once both have.
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (aw_ok && w_ok) state_q <= S_WR_B;
        end
        S_WR_B: begin
          if (host_resp_i.b_valid) begin
            resp_data_q <= '0;
            resp_err_q  <= (host_resp_i.b.resp != AXI_RESP_OKAY);
            state_q     <= S_RESP;
          end
        end
`ifdef PSPIN_HOSTDIRECT_READ_EN
        S_RD_REQ: begin
          if (ar_hs) state_q <= S_RD_R;
        end
        S_RD_R: begin
          if (r_hs) begin
            resp_data_q <= rd_data;
            resp_err_q  <= (host_resp_i.r.resp != AXI_RESP_OKAY);
            state_q     <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (cmd_resp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Fields of the command and AXI response that this block does not consume.
  logic unused_inputs;
`ifdef PSPIN_HOSTDIRECT_READ_EN
  assign unused_inputs = ^{cmd_i.cmd_type, cmd_i.intf_id, cmd_i.generate_event,
                           host_resp_i.b.id, host_resp_i.b.user,
                           host_resp_i.r.id, host_resp_i.r.last, host_resp_i.r.user};
`else
  assign unused_inputs = ^{cmd_i.cmd_type, cmd_i.intf_id, cmd_i.generate_event,
                           host_resp_i.b.id, host_resp_i.b.user,
                           host_resp_i.ar_ready, host_resp_i.r_valid, host_resp_i.r};
`endif

endmodule

// File: tb/tb_host_direct_responder.sv
// Directed bench for host_direct_responder: writes (aligned, offset, boundary,
// SLVERR with response backpressure), illegal commands, reads (or their
// rejection when PSPIN_HOSTDIRECT_READ_EN is undefined), and asynchronous reset.

module tb_host_direct_responder;

  import pspin_cfg_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  pspin_cmd_t      cmd;
  host_req_t       host_req;
  host_resp_t      host_resp;
  logic            cmd_resp_valid;
  logic            cmd_resp_ready;
  pspin_cmd_resp_t cmd_resp;
  logic            cmd_resp_err;

  int vectors;
  int miscompares;

  host_direct_responder #(.AXI_ID(3)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_i            (cmd),
    .host_req_o       (host_req),
    .host_resp_i      (host_resp),
    .cmd_resp_valid_o (cmd_resp_valid),
    .cmd_resp_ready_i (cmd_resp_ready),
    .cmd_resp_o       (cmd_resp),
    .cmd_resp_err_o   (cmd_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [15:0] id, input logic [63:0] addr,
                         input logic [511:0] data, input logic [31:0] size, input logic n2h);
    cmd = '0;
    cmd.cmd_id                              = id;
    cmd.cmd_type                            = 2'd2;
    cmd.intf_id                             = 1'b1;
    cmd.descr.host_direct_cmd.host_addr     = addr;
    cmd.descr.host_direct_cmd.imm_data      = data;
    cmd.descr.host_direct_cmd.imm_data_size = size;
    cmd.descr.host_direct_cmd.nic_to_host   = n2h;
  endtask

  // Offer the current command for exactly one edge (DUT must be idle).
  task automatic accept();
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [511:0] rdata;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd            = '0;
    host_resp      = '0;
    cmd_resp_ready = 1'b1;

    // ---- reset values ----
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_aw_valid", host_req.aw_valid, 1'b0);
    check("rst_w_valid", host_req.w_valid, 1'b0);
    check("rst_ar_valid", host_req.ar_valid, 1'b0);
    check("rst_b_ready", host_req.b_ready, 1'b0);
    check("rst_r_ready", host_req.r_ready, 1'b0);
    check("rst_resp_valid", cmd_resp_valid, 1'b0);
    check("rst_resp_id", cmd_resp.cmd_id, 16'h0);
    check("rst_resp_data", cmd_resp.imm_data, 512'h0);
    check("rst_resp_err", cmd_resp_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---- aligned write, zero-latency slave ----
    set_cmd(16'h0011, 64'h1_0000_0040, {16{32'hA5A5_0001}}, 32'd64, 1'b1);
    accept();
    check("al_aw_valid", host_req.aw_valid, 1'b1);
    check("al_w_valid", host_req.w_valid, 1'b1);
    check("al_cmd_ready", cmd_ready, 1'b0);
    check("al_aw_addr", host_req.aw.addr, 64'h1_0000_0040);
    check("al_aw_len", host_req.aw.len, 8'd0);
    check("al_aw_size", host_req.aw.size, 3'd6);
    check("al_aw_burst", host_req.aw.burst, 2'b01);
    check("al_aw_id", host_req.aw.id, 8'd3);
    check("al_w_strb", host_req.w.strb, 64'hFFFF_FFFF_FFFF_FFFF);
    check("al_w_data", host_req.w.data, {16{32'hA5A5_0001}});
    check("al_w_last", host_req.w.last, 1'b1);
    host_resp.aw_ready = 1'b1;
    host_resp.w_ready  = 1'b1;
    tick();
    host_resp.aw_ready = 1'b0;
    host_resp.w_ready  = 1'b0;
    check("al_wrb_aw_valid", host_req.aw_valid, 1'b0);
    check("al_wrb_w_valid", host_req.w_valid, 1'b0);
    check("al_b_ready", host_req.b_ready, 1'b1);
    host_resp.b_valid = 1'b1;
    host_resp.b.resp  = 2'b00;
    tick();
    host_resp.b_valid = 1'b0;
    check("al_resp_valid", cmd_resp_valid, 1'b1);
    check("al_resp_id", cmd_resp.cmd_id, 16'h0011);
    check("al_resp_err", cmd_resp_err, 1'b0);
    check("al_resp_data", cmd_resp.imm_data, 512'h0);
    tick();
    check("al_back_idle", cmd_ready, 1'b1);
    check("al_resp_drop", cmd_resp_valid, 1'b0);

    // ---- offset write, AW and W accepted on different cycles ----
    set_cmd(16'h0022, 64'h1_0000_0047, 512'hDEAD_BEEF, 32'd4, 1'b1);
    accept();
    check("of_aw_addr", host_req.aw.addr, 64'h1_0000_0040);
    check("of_w_strb", host_req.w.strb, 64'h0000_0000_0000_0780);
    check("of_w_slice", host_req.w.data[87:56], 32'hDEAD_BEEF);
    check("of_w_data", host_req.w.data, 512'hDEAD_BEEF_0000_0000_0000_00);
    host_resp.aw_ready = 1'b1;
    tick();
    host_resp.aw_ready = 1'b0;
    check("of_aw_dropped", host_req.aw_valid, 1'b0);
    check("of_w_held", host_req.w_valid, 1'b1);
    check("of_no_b_ready", host_req.b_ready, 1'b0);
    host_resp.w_ready = 1'b1;
    tick();
    host_resp.w_ready = 1'b0;
    check("of_w_dropped", host_req.w_valid, 1'b0);
    check("of_b_ready", host_req.b_ready, 1'b1);
    host_resp.b_valid = 1'b1;
    tick();
    host_resp.b_valid = 1'b0;
    check("of_resp_valid", cmd_resp_valid, 1'b1);
    check("of_resp_id", cmd_resp.cmd_id, 16'h0022);
    check("of_resp_err", cmd_resp_err, 1'b0);
    tick();

    // ---- boundary: off 60 + n 4 ends exactly at the line end, legal ----
    set_cmd(16'h0033, 64'h1_0000_007C, 512'h1234_5678, 32'd4, 1'b1);
    accept();
    check("bd_aw_valid", host_req.aw_valid, 1'b1);
    check("bd_w_strb", host_req.w.strb, 64'hF000_0000_0000_0000);
    check("bd_w_data_hi", host_req.w.data[511:480], 32'h1234_5678);
    host_resp.aw_ready = 1'b1;
    host_resp.w_ready  = 1'b1;
    tick();
    host_resp.aw_ready = 1'b0;
    host_resp.w_ready  = 1'b0;
    host_resp.b_valid  = 1'b1;
    tick();
    host_resp.b_valid  = 1'b0;
    check("bd_resp_valid", cmd_resp_valid, 1'b1);
    tick();

    // ---- illegal commands: line crossing, n=0, n=65 ----
    set_cmd(16'h0044, 64'h1_0000_007E, 512'hFFFF_FFFF, 32'd4, 1'b1);
    accept();
    check("lc_resp_valid", cmd_resp_valid, 1'b1);
    check("lc_resp_err", cmd_resp_err, 1'b1);
    check("lc_resp_data", cmd_resp.imm_data, 512'h0);
    check("lc_resp_id", cmd_resp.cmd_id, 16'h0044);
    check("lc_aw_valid", host_req.aw_valid, 1'b0);
    check("lc_w_valid", host_req.w_valid, 1'b0);
    check("lc_ar_valid", host_req.ar_valid, 1'b0);
    tick();
    check("lc_back_idle", cmd_ready, 1'b1);
    check("lc_aw_after", host_req.aw_valid, 1'b0);

    set_cmd(16'h0045, 64'h1_0000_0000, 512'h1, 32'd0, 1'b1);
    accept();
    check("n0_resp_valid", cmd_resp_valid, 1'b1);
    check("n0_resp_err", cmd_resp_err, 1'b1);
    check("n0_aw_valid", host_req.aw_valid, 1'b0);
    tick();

    set_cmd(16'h0046, 64'h1_0000_0000, 512'h1, 32'd65, 1'b1);
    accept();
    check("n65_resp_valid", cmd_resp_valid, 1'b1);
    check("n65_resp_err", cmd_resp_err, 1'b1);
    check("n65_aw_valid", host_req.aw_valid, 1'b0);
    tick();

    // ---- SLVERR with response backpressure ----
    cmd_resp_ready = 1'b0;
    set_cmd(16'h0055, 64'h1_0000_0080, 512'h1122_3344_5566_7788, 32'd8, 1'b1);
    accept();
    host_resp.aw_ready = 1'b1;
    host_resp.w_ready  = 1'b1;
    tick();
    host_resp.aw_ready = 1'b0;
    host_resp.w_ready  = 1'b0;
    host_resp.b_valid  = 1'b1;
    host_resp.b.resp   = 2'b10;
    tick();
    host_resp.b_valid  = 1'b0;
    host_resp.b.resp   = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("se_valid_%0d", i), cmd_resp_valid, 1'b1);
      check($sformatf("se_err_%0d", i), cmd_resp_err, 1'b1);
      check($sformatf("se_id_%0d", i), cmd_resp.cmd_id, 16'h0055);
      check($sformatf("se_data_%0d", i), cmd_resp.imm_data, 512'h0);
      check($sformatf("se_cmd_ready_%0d", i), cmd_ready, 1'b0);
      tick();
    end
    cmd_resp_ready = 1'b1;
    tick();
    check("se_back_idle", cmd_ready, 1'b1);
    check("se_resp_drop", cmd_resp_valid, 1'b0);

`ifdef PSPIN_HOSTDIRECT_READ_EN
    // ---- offset read ----
    set_cmd(16'h0066, 64'h1_0000_0010, 512'h0, 32'd8, 1'b0);
    accept();
    check("rd_ar_valid", host_req.ar_valid, 1'b1);
    check("rd_ar_addr", host_req.ar.addr, 64'h1_0000_0000);
    check("rd_ar_size", host_req.ar.size, 3'd6);
    check("rd_aw_valid", host_req.aw_valid, 1'b0);
    host_resp.ar_ready = 1'b1;
    tick();
    host_resp.ar_ready = 1'b0;
    check("rd_ar_dropped", host_req.ar_valid, 1'b0);
    check("rd_r_ready", host_req.r_ready, 1'b1);
    rdata = '1;
    rdata[191:128] = 64'h0123_4567_89AB_CDEF;
    host_resp.r_valid = 1'b1;
    host_resp.r.data  = rdata;
    host_resp.r.resp  = 2'b00;
    host_resp.r.last  = 1'b1;
    tick();
    host_resp.r_valid = 1'b0;
    check("rd_resp_valid", cmd_resp_valid, 1'b1);
    check("rd_resp_id", cmd_resp.cmd_id, 16'h0066);
    check("rd_resp_data", cmd_resp.imm_data, 512'h0123_4567_89AB_CDEF);
    check("rd_resp_err", cmd_resp_err, 1'b0);
    tick();
`else
    // ---- read requested while reads are compiled out ----
    set_cmd(16'h0066, 64'h1_0000_0010, 512'h0, 32'd8, 1'b0);
    accept();
    check("rdoff_resp_valid", cmd_resp_valid, 1'b1);
    check("rdoff_resp_err", cmd_resp_err, 1'b1);
    check("rdoff_resp_data", cmd_resp.imm_data, 512'h0);
    check("rdoff_ar_valid", host_req.ar_valid, 1'b0);
    check("rdoff_r_ready", host_req.r_ready, 1'b0);
    tick();
    check("rdoff_ar_after", host_req.ar_valid, 1'b0);
`endif

    // ---- asynchronous reset while waiting for B ----
    set_cmd(16'h0077, 64'h1_0000_0100, 512'hAB, 32'd1, 1'b1);
    accept();
    host_resp.aw_ready = 1'b1;
    host_resp.w_ready  = 1'b1;
    tick();
    host_resp.aw_ready = 1'b0;
    host_resp.w_ready  = 1'b0;
    check("ar_in_wrb", host_req.b_ready, 1'b1);
    check("ar_id_before", cmd_resp.cmd_id, 16'h0077);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_b_ready", host_req.b_ready, 1'b0);
    check("ar_cmd_ready", cmd_ready, 1'b1);
    check("ar_resp_valid", cmd_resp_valid, 1'b0);
    check("ar_resp_id", cmd_resp.cmd_id, 16'h0);
    check("ar_resp_err", cmd_resp_err, 1'b0);
    check("ar_aw_valid", host_req.aw_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    host_resp.b_valid = 1'b1;
    tick();
    host_resp.b_valid = 1'b0;
    check("ar_late_b_resp", cmd_resp_valid, 1'b0);
    check("ar_late_b_idle", cmd_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
